ff_fifo_drain_packer: RTL and testbench
=======================================

// Module: ff_fifo_drain_packer
// PURPOSE
//  Downstream stage of the register-flag FIFO: pops narrow words while the FIFO is non-empty.
//  Packs RATIO consecutive words into one wide word and offers it on a valid/ready output.
//  flush emits a partially filled word at packet end. Sits between the FIFO and a wide consumer.
// PARAMETERS
//  width   8   FIFO word width, bits
//  ratio   4   words packed per output word; ratio >= 1
// PORTS
//  clk              in   1              clock; all state on posedge
//  rst              in   1              synchronous active-high reset
//  fifo_empty       in   1              FIFO empty flag; fifo_read_data valid when 0
//  fifo_read_data   in   width          FIFO head word, combinational from FIFO
//  fifo_pop         out  1              pop FIFO head this cycle (combinational)
//  flush            in   1              single-cycle request to emit partial word
//  out_valid        out  1              out_data/out_count valid
//  out_ready        in   1              consumer accepts when out_valid & out_ready
//  out_data         out  width*ratio    packed word; first popped word in bits [width-1:0]
//  out_count        out  $clog2(ratio+1) number of valid words in out_data (1..ratio)
// BEHAVIOUR
//  - Reset: out_valid=0, out_data=0, out_count=0, word count cnt=0, flush_pending=0, accumulator=0.
//  - fifo_pop is 0 while rst=1.
//  - State: accumulator acc[ratio] words, cnt 0..ratio, flush_pending, output register.
//  - out_free = !out_valid | out_ready.
//  - load = out_free & (cnt==ratio | (flush_pending & cnt!=0)).
//  - fifo_pop = !rst & !fifo_empty & !flush_pending & (cnt<ratio | load).
//  - pop writes fifo_read_data into acc[cnt]; when load also occurs, it writes acc[0] instead.
//  - cnt_next = load ? pop : cnt + pop. The sum is computed in counter width; no overflow by construction.
//  - On load: out_data<=acc, words >= cnt forced to 0; out_count<=cnt; out_valid<=1.
//  - No load & out_ready: out_valid<=0; out_data/out_count hold their last value.
//  - out_valid=1 & !out_ready: out_data/out_count/out_valid held stable (AXI-style rule).
//  - Latency: last word popped in cycle t gives out_valid=1 in cycle t+2 when the output is free.
//  - Sustained throughput 1 word/cycle: a full accumulator loads and accepts a new pop in the same cycle.
//  - Flush handshake:
//    - flush sets flush_pending at the next edge.
//    - A pop in the same cycle as flush still completes and is included in the flushed word.
//    - While flush_pending, no pops.
//    - cnt!=0: pending clears on the load cycle.
//    - cnt==0: pending clears next cycle with no output.
//    - flush while already pending: ignored.
//  - cnt==ratio with output stalled: pops stop (FIFO fills upstream); no words lost or reordered.
//  - ratio=1: registered passthrough; out_count always 1.
//  - Reset mid-operation: partial accumulator and pending output are discarded; all regs return to reset values.
// TESTING
//  1. rst=1 two cycles, fifo_empty=0 -> fifo_pop=0, out_valid=0, out_data=0, out_count=0.
//  2. FIFO supplies 0x11,0x22,0x33,0x44, out_ready=1 -> 4 consecutive pops;
//     2 cycles after last pop: out_data=0x44332211, out_count=4, out_valid=1 for 1 cycle.
//  3. 8 words 0x01..0x08, out_ready=0 -> out_data=0x04030201 held stable; pops stop after 8 words.
//     Raise out_ready -> 0x04030201 taken, then 0x08070605 next cycle.
//  4. Words 0xA1,0xA2,0xA3 then flush -> out_data=0x00A3A2A1, out_count=3; no pop while pending.
//  5. flush with cnt=0 and empty FIFO -> no out_valid; pending clears, next 4 words pack normally.
//  6. cnt=2 and out_valid=1, assert rst one cycle -> all cleared; next 4 words 0xB1..0xB4 -> 0xB4B3B2B1.

Source files
------------

// File: rtl/ff_fifo_drain_packer.sv
// Drains a narrow FIFO and packs RATIO consecutive words into one wide word on a
// valid/ready output; flush emits a partially filled word at packet end.
module ff_fifo_drain_packer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned RATIO = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_fifo_empty,
  input  logic [WIDTH-1:0]             i_fifo_read_data,
  output logic                         o_fifo_pop,
  input  logic                         i_flush,
  output logic                         o_out_valid,
  input  logic                         i_out_ready,
  output logic [WIDTH*RATIO-1:0]       o_out_data,
  output logic [$clog2(RATIO+1)-1:0]   o_out_count
);

  localparam int unsigned CW = $clog2(RATIO + 1);
  localparam int unsigned OW = WIDTH * RATIO;

  logic [RATIO-1:0][WIDTH-1:0] r_acc;
  logic [CW-1:0]               r_cnt;
  logic                        r_flush_pending;
  logic                        r_out_valid;
  logic [OW-1:0]               r_out_data;
  logic [CW-1:0]               r_out_count;

  logic                        w_out_free;
  logic                        w_full;
  logic                        w_load;
  logic                        w_pop;
  logic [CW-1:0]               w_wr_idx;
  logic [CW-1:0]               w_cnt_next;
  logic [RATIO-1:0][WIDTH-1:0] w_load_data;

  // Load/pop decisions; a full accumulator can unload and refill in one cycle.
  always_comb begin
    w_out_free  = !r_out_valid || i_out_ready;
    w_full      = (r_cnt == CW'(RATIO));
    w_load      = w_out_free && (w_full || (r_flush_pending && (r_cnt != '0)));
    w_pop       = !i_rst && !i_fifo_empty && !r_flush_pending && (!w_full || w_load);
    w_wr_idx    = w_load ? '0 : r_cnt;
    w_cnt_next  = w_load ? CW'(w_pop) : r_cnt + CW'(w_pop);
    w_load_data = '0;
    for (int unsigned i = 0; i < RATIO; i++) begin
      w_load_data[i] = (CW'(i) < r_cnt) ? r_acc[i] : '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc           <= '0;
      r_cnt           <= '0;
      r_flush_pending <= 1'b0;
      r_out_valid     <= 1'b0;
      r_out_data      <= '0;
      r_out_count     <= '0;
    end else begin
      r_cnt <= w_cnt_next;
      for (int unsigned i = 0; i < RATIO; i++) begin
        if (w_pop && (w_wr_idx == CW'(i))) begin
          r_acc[i] <= i_fifo_read_data;
        end
      end
      // Pending flush retires on its load, or immediately when nothing is buffered.
      if (r_flush_pending) begin
        if (w_load || (r_cnt == '0)) begin
          r_flush_pending <= 1'b0;
        end
      end else if (i_flush) begin
        r_flush_pending <= 1'b1;
      end
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_load_data;
        r_out_count <= r_cnt;
      end else if (i_out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign o_fifo_pop  = w_pop;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_out_count = r_out_count;

endmodule

// File: tb/tb_ff_fifo_drain_packer.sv
// Directed bench for ff_fifo_drain_packer: queue-modelled source FIFO and an
// expected-word scoreboard checked whenever an output word is accepted.
module tb_ff_fifo_drain_packer;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned RATIO = 4;
  localparam int unsigned CW    = $clog2(RATIO + 1);

  typedef struct {
    logic [WIDTH*RATIO-1:0] data;
    logic [CW-1:0]          count;
  } exp_t;

  logic                    clk = 1'b0;
  logic                    i_rst = 1'b1;
  logic                    i_fifo_empty = 1'b1;
  logic [WIDTH-1:0]        i_fifo_read_data = '0;
  logic                    o_fifo_pop;
  logic                    i_flush = 1'b0;
  logic                    o_out_valid;
  logic                    i_out_ready = 1'b0;
  logic [WIDTH*RATIO-1:0]  o_out_data;
  logic [CW-1:0]           o_out_count;

  ff_fifo_drain_packer #(.WIDTH(WIDTH), .RATIO(RATIO)) dut (
    .i_clk            (clk),
    .i_rst            (i_rst),
    .i_fifo_empty     (i_fifo_empty),
    .i_fifo_read_data (i_fifo_read_data),
    .o_fifo_pop       (o_fifo_pop),
    .i_flush          (i_flush),
    .o_out_valid      (o_out_valid),
    .i_out_ready      (i_out_ready),
    .o_out_data       (o_out_data),
    .o_out_count      (o_out_count)
  );

  always #5 clk = ~clk;

  logic [WIDTH-1:0] src[$];
  exp_t             exp_q[$];
  int               acc_cyc[$];
  int n_cmp = 0, n_fail = 0;
  int cyc = 0, n_pops = 0, first_pop = -1, last_pop = -1;
  int valid_cycles = 0, first_valid = -1;
  logic                   s_pop, s_valid;
  logic [WIDTH*RATIO-1:0] s_data;
  logic [CW-1:0]          s_count;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    n_pops = 0; first_pop = -1; last_pop = -1;
    valid_cycles = 0; first_valid = -1;
    acc_cyc.delete();
  endtask

  // One clock: present FIFO head, sample outputs mid-cycle, retire popped word at the edge.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    i_fifo_empty     = (src.size() == 0);
    i_fifo_read_data = (src.size() != 0) ? src[0] : '0;
    #1;
    s_pop = o_fifo_pop; s_valid = o_out_valid; s_data = o_out_data; s_count = o_out_count;
    if (s_pop) begin
      n_pops++;
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
    end
    if (s_valid) begin
      valid_cycles++;
      if (first_valid < 0) first_valid = cyc;
    end
    if (s_valid && i_out_ready) begin
      acc_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_out", 64'(s_data), 64'hdead);
      end else begin
        e = exp_q.pop_front();
        check("out_data", 64'(s_data), 64'(e.data));
        check("out_count", 64'(s_count), 64'(e.count));
      end
    end
    @(posedge clk);
    if (s_pop && src.size() != 0) void'(src.pop_front());
    cyc++;
    #1;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  initial begin
    // 1: reset with a non-empty FIFO
    i_rst = 1'b1;
    src.push_back(8'h5A);
    for (int k = 0; k < 2; k++) begin
      cycle();
      check("rst_pop", 64'(s_pop), 64'd0);
      check("rst_valid", 64'(s_valid), 64'd0);
      check("rst_data", 64'(s_data), 64'd0);
      check("rst_count", 64'(s_count), 64'd0);
    end
    src.delete();
    i_rst = 1'b0;

    // 2: four words pack into one, latency two cycles after last pop
    clr();
    i_out_ready = 1'b1;
    src = '{8'h11, 8'h22, 8'h33, 8'h44};
    exp_q.push_back('{32'h44332211, 3'd4});
    run(8);
    check("b_pops", 64'(n_pops), 64'd4);
    check("b_pop_span", 64'(last_pop - first_pop), 64'd3);
    check("b_latency", 64'(first_valid - last_pop), 64'd2);
    check("b_valid_cycles", 64'(valid_cycles), 64'd1);

    // 3: stalled output holds, pops stop at eight words, then drains in order
    clr();
    i_out_ready = 1'b0;
    for (int k = 1; k <= 12; k++) src.push_back(8'(k));
    exp_q.push_back('{32'h04030201, 3'd4});
    exp_q.push_back('{32'h08070605, 3'd4});
    exp_q.push_back('{32'h0C0B0A09, 3'd4});
    for (int k = 0; k < 12; k++) begin
      cycle();
      if (s_valid) check("stall_hold", 64'(s_data), 64'h04030201);
    end
    check("stall_pops", 64'(n_pops), 64'd8);
    check("stall_valid", 64'(s_valid), 64'd1);
    i_out_ready = 1'b1;
    run(10);
    check("drain_accepts", 64'(acc_cyc.size()), 64'd3);
    if (acc_cyc.size() >= 2) check("drain_b2b", 64'(acc_cyc[1] - acc_cyc[0]), 64'd1);

    // 4: flush of a partial word; no pops while pending
    clr();
    src = '{8'hA1, 8'hA2, 8'hA3};
    exp_q.push_back('{32'h00A3A2A1, 3'd3});
    exp_q.push_back('{32'hC4C3C2C1, 3'd4});
    run(3);
    i_flush = 1'b1;
    cycle();
    i_flush = 1'b0;
    src = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
    cycle();
    check("no_pop_pending", 64'(s_pop), 64'd0);
    run(10);
    check("flush_pops", 64'(n_pops), 64'd7);

    // 5: flush with nothing buffered produces no output
    clr();
    i_flush = 1'b1;
    cycle();
    i_flush = 1'b0;
    run(4);
    check("empty_flush_valid", 64'(valid_cycles), 64'd0);
    src = '{8'hD1, 8'hD2, 8'hD3, 8'hD4};
    exp_q.push_back('{32'hD4D3D2D1, 3'd4});
    run(8);
    check("after_flush_pops", 64'(n_pops), 64'd4);
    check("after_flush_drained", 64'(exp_q.size()), 64'd0);

    // 6: reset with a pending output and a partial accumulator
    clr();
    i_out_ready = 1'b0;
    src = '{8'hE1, 8'hE2, 8'hE3, 8'hE4, 8'hF1, 8'hF2};
    run(10);
    check("pre_rst_pops", 64'(n_pops), 64'd6);
    check("pre_rst_valid", 64'(s_valid), 64'd1);
    i_rst = 1'b1;
    cycle();
    check("mid_rst_pop", 64'(s_pop), 64'd0);
    i_rst = 1'b0;
    cycle();
    check("post_rst_valid", 64'(s_valid), 64'd0);
    check("post_rst_data", 64'(s_data), 64'd0);
    check("post_rst_count", 64'(s_count), 64'd0);
    i_out_ready = 1'b1;
    src = '{8'hB1, 8'hB2, 8'hB3, 8'hB4};
    exp_q.push_back('{32'hB4B3B2B1, 3'd4});
    run(8);
    check("final_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
